// File: rtl/jump_sequencer.sv
// Game-phase controller for the doodle datapath: sequences INIT/UP/DOWN/DONE,
// and drives the platform scroll offset, the score and the landing count.
module jump_sequencer #(
    parameter int STEP        = 2,
    parameter int JUMP_HEIGHT = 100,
    parameter int SCROLL_LINE = 200,
    parameter int FLOOR_Y     = 515
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] ypos,
    input  logic       on_platform,
    output logic       q_I,
    output logic       q_Up,
    output logic       q_Down,
    output logic       q_Done,
    output logic       scroll_en,
    output logic [9:0] scroll_offset,
    output logic [7:0] score,
    output logic [7:0] jump_cnt
);

    // One-hot state: the phase strobes are the state bits themselves.
    localparam logic [3:0] S_INIT = 4'b0001;
    localparam logic [3:0] S_UP   = 4'b0010;
    localparam logic [3:0] S_DOWN = 4'b0100;
    localparam logic [3:0] S_DONE = 4'b1000;

    localparam logic [9:0]  LP_STEP10  = 10'(STEP);
    localparam logic [15:0] LP_STEP16  = 16'(STEP);
    localparam logic [16:0] LP_JUMP17  = 17'(JUMP_HEIGHT);
    localparam logic [9:0]  LP_SCROLL  = 10'(SCROLL_LINE);
    localparam logic [9:0]  LP_FLOOR   = 10'(FLOOR_Y);

    logic [3:0]  r_state;
    logic [15:0] r_rise_cnt;
    logic [9:0]  r_scroll_offset;
    logic [7:0]  r_score;
    logic [7:0]  r_jump_cnt;
    logic [16:0] w_rise_sum;
    logic        w_scroll;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_rise_sum = {1'b0, r_rise_cnt} + {1'b0, LP_STEP16};
    assign w_scroll   = tick && (r_state == S_UP) && (ypos <= LP_SCROLL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_INIT;
            r_rise_cnt      <= '0;
            r_scroll_offset <= '0;
            r_score         <= '0;
            r_jump_cnt      <= '0;
        end else if (tick) begin
            case (r_state)
                S_INIT: begin
                    r_rise_cnt      <= '0;
                    r_scroll_offset <= '0;
                    r_score         <= '0;
                    r_jump_cnt      <= '0;
                    if (start) r_state <= S_UP;
                end
                S_UP: begin
                    // The offset wraps naturally at 1024; the score saturates.
                    if (w_scroll) begin
                        r_scroll_offset <= r_scroll_offset + LP_STEP10;
                        r_score         <= sat_inc8(r_score);
                    end
                    if (w_rise_sum >= LP_JUMP17) begin
                        r_rise_cnt <= '0;
                        r_state    <= S_DOWN;
                    end else begin
                        r_rise_cnt <= w_rise_sum[15:0];
                    end
                end
                S_DOWN: begin
                    // A landing takes priority over touching the floor.
                    if (on_platform) begin
                        r_rise_cnt <= '0;
                        r_jump_cnt <= sat_inc8(r_jump_cnt);
                        r_state    <= S_UP;
                    end else if (ypos >= LP_FLOOR) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (start) r_state <= S_INIT;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign q_I           = r_state[0];
    assign q_Up          = r_state[1];
    assign q_Down        = r_state[2];
    assign q_Done        = r_state[3];
    assign scroll_en     = w_scroll;
    assign scroll_offset = r_scroll_offset;
    assign score         = r_score;
    assign jump_cnt      = r_jump_cnt;

endmodule

// File: tb/tb_jump_sequencer.sv
// Bench for jump_sequencer: fixed vector table, directed phase sequences and
// randomized traffic, all compared against a phase-level reference model.
module tb_jump_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       start;
    logic [9:0] ypos;
    logic       on_platform;
    logic       q_I, q_Up, q_Down, q_Done, scroll_en;
    logic [9:0] scroll_offset;
    logic [7:0] score, jump_cnt;

    jump_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .ypos(ypos),
        .on_platform(on_platform), .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down),
        .q_Done(q_Done), .scroll_en(scroll_en), .scroll_offset(scroll_offset),
        .score(score), .jump_cnt(jump_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: phase 0=INIT 1=UP 2=DOWN 3=DONE, pixel counts as ints.
    int m_phase, m_risen, m_off, m_score, m_jumps;
    logic last_se;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_risen = 0; m_off = 0; m_score = 0; m_jumps = 0;
    endtask

    function automatic int model_scroll(input logic t, input logic [9:0] y);
        return (t && m_phase == 1 && int'(y) <= 200) ? 1 : 0;
    endfunction

    task automatic model_step(input logic t, input logic s, input logic [9:0] y, input logic p);
        if (!t) return;
        case (m_phase)
            0: begin
                m_off = 0; m_score = 0; m_jumps = 0; m_risen = 0;
                if (s) m_phase = 1;
            end
            1: begin
                if (int'(y) <= 200) begin
                    m_off   = (m_off + 2) % 1024;
                    m_score = (m_score >= 255) ? 255 : m_score + 1;
                end
                m_risen += 2;
                if (m_risen >= 100) begin
                    m_phase = 2;
                    m_risen = 0;
                end
            end
            2: begin
                if (p) begin
                    m_phase = 1;
                    m_risen = 0;
                    m_jumps = (m_jumps >= 255) ? 255 : m_jumps + 1;
                end else if (int'(y) >= 515) begin
                    m_phase = 3;
                end
            end
            default: if (s) m_phase = 0;
        endcase
    endtask

    task automatic chk_state();
        chk("phase", int'({q_Done, q_Down, q_Up, q_I}), 1 << m_phase);
        chk("onehot", int'($onehot({q_Done, q_Down, q_Up, q_I})), 1);
        chk("scroll_offset", int'(scroll_offset), m_off);
        chk("score", int'(score), m_score);
        chk("jump_cnt", int'(jump_cnt), m_jumps);
    endtask

    // Called at a negedge; drives one cycle and returns at the next negedge.
    task automatic cycle(input logic t, input logic s, input logic [9:0] y, input logic p);
        tick = t; start = s; ypos = y; on_platform = p;
        #1;
        last_se = scroll_en;
        chk("scroll_en", int'(scroll_en), model_scroll(t, y));
        @(posedge clk);
        model_step(t, s, y, p);
        @(negedge clk);
        chk_state();
    endtask

    typedef struct {
        logic       t;
        logic       s;
        logic [9:0] y;
        logic       p;
        logic [3:0] ph;
        logic       se;
        int         off;
        int         sc;
        int         jc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        int guard;
        int n_scroll;

        vecs[0] = '{1'b1, 1'b0, 10'd400, 1'b0, 4'b0001, 1'b0, 0, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 10'd400, 1'b0, 4'b0010, 1'b0, 0, 0, 0};
        vecs[2] = '{1'b1, 1'b0, 10'd180, 1'b0, 4'b0010, 1'b1, 2, 1, 0};
        vecs[3] = '{1'b0, 1'b0, 10'd180, 1'b0, 4'b0010, 1'b0, 2, 1, 0};
        vecs[4] = '{1'b1, 1'b0, 10'd180, 1'b0, 4'b0010, 1'b1, 4, 2, 0};
        vecs[5] = '{1'b1, 1'b0, 10'd400, 1'b0, 4'b0010, 1'b0, 4, 2, 0};
        vecs[6] = '{1'b1, 1'b1, 10'd400, 1'b0, 4'b0010, 1'b0, 4, 2, 0};

        rst = 1'b1; tick = 1'b0; start = 1'b0; ypos = 10'd400; on_platform = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_state();

        // Idle in INIT
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 10'd400, 1'b0);
        chk("init_q_I", int'(q_I), 1);

        // Fixed vector table
        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].t, vecs[i].s, vecs[i].y, vecs[i].p);
            chk($sformatf("vec%0d_se", i), int'(last_se), int'(vecs[i].se));
            chk($sformatf("vec%0d_phase", i), int'({q_Done, q_Down, q_Up, q_I}), int'(vecs[i].ph));
            chk($sformatf("vec%0d_off", i), int'(scroll_offset), vecs[i].off);
            chk($sformatf("vec%0d_score", i), int'(score), vecs[i].sc);
            chk($sformatf("vec%0d_jumps", i), int'(jump_cnt), vecs[i].jc);
        end

        // Asynchronous reset mid-jump, observed before the next clock edge
        tick = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_q_I", int'(q_I), 1);
        chk("async_rst_q_Up", int'(q_Up), 0);
        chk("async_rst_score", int'(score), 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_state();

        // Full jump without scrolling lasts 50 ticks
        cycle(1'b1, 1'b1, 10'd400, 1'b0);
        n = 0;
        while (q_Up && n < 200) begin
            cycle(1'b1, 1'b0, 10'd400, 1'b0);
            n++;
        end
        chk("up_ticks", n, 50);
        chk("up_then_down", int'(q_Down), 1);
        chk("no_scroll_score", int'(score), 0);

        // Start ignored in DOWN, then landing wins over the floor
        cycle(1'b1, 1'b1, 10'd400, 1'b0);
        chk("start_in_down", int'(q_Down), 1);
        cycle(1'b1, 1'b0, 10'd515, 1'b1);
        chk("land_q_Up", int'(q_Up), 1);
        chk("land_q_Done", int'(q_Done), 0);
        chk("land_jumps", int'(jump_cnt), 1);

        // Rise again, then die on the floor and restart
        n = 0;
        while (q_Up && n < 200) begin
            cycle(1'b1, 1'b0, 10'd400, 1'b0);
            n++;
        end
        chk("up_ticks_2", n, 50);
        cycle(1'b1, 1'b0, 10'd515, 1'b0);
        chk("death_q_Done", int'(q_Done), 1);
        cycle(1'b1, 1'b0, 10'd400, 1'b0);
        chk("done_frozen_jumps", int'(jump_cnt), 1);
        cycle(1'b1, 1'b1, 10'd400, 1'b0);
        chk("restart_q_I", int'(q_I), 1);
        cycle(1'b1, 1'b0, 10'd400, 1'b0);
        chk("restart_jumps", int'(jump_cnt), 0);

        // Score saturation and scroll offset wrap
        cycle(1'b1, 1'b1, 10'd400, 1'b0);
        n_scroll = 0;
        guard = 0;
        while (n_scroll < 512 && guard < 5000) begin
            if (q_Up) begin
                cycle(1'b1, 1'b0, 10'd180, 1'b0);
                n_scroll++;
                if (n_scroll == 300) begin
                    chk("sat_score", int'(score), 255);
                    chk("off_600", int'(scroll_offset), 600);
                end
            end else begin
                cycle(1'b1, 1'b0, 10'd400, 1'b1);
            end
            guard++;
        end
        chk("scroll_count", n_scroll, 512);
        chk("off_wrap", int'(scroll_offset), 0);
        chk("score_held", int'(score), 255);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] y;
            case ($urandom_range(0, 7))
                0: y = 10'd150;
                1: y = 10'd200;
                2: y = 10'd201;
                3: y = 10'd514;
                4: y = 10'd515;
                5: y = 10'd600;
                default: y = 10'($urandom_range(0, 1023));
            endcase
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0),
                  y, 1'($urandom_range(0, 9) < 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
